// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST sequencer.
package gate_bist_pkg;

   // Sequencer states: waiting for a request, stepping vectors, reporting
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Reference truth tables, bit index = {x,y}
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_timer.sv
// Settle timer: counts SETTLE_CYCLES-1 down to 0 and reloads on request.
module gate_bist_timer #(
   parameter int SETTLE_CYCLES = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic zero
);

   // A single-cycle settle time still needs a one-bit counter that sits at 0
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(SETTLE_CYCLES - 1);

   logic [TW-1:0] count;

   // Reload holds the count at its start value; otherwise count down and stop at 0
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= RELOAD;
      end else if (load) begin
         count <= RELOAD;
      end else if (count != '0) begin
         count <= count - TW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/gate_bist.sv
// Gate BIST sequencer: walks {x,y} through 00,01,10,11, samples z after each
// settle period and compares the captured truth table against EXPECTED.
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 7,
   parameter logic [3:0] EXPECTED      = TT_NAND
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       z,
   output logic       x,
   output logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] observed,
   output logic [3:0] fail_mask
);

   state_t     state;
   state_t     state_next;
   logic [1:0] vec;
   logic [1:0] vec_inc;
   logic [3:0] obs_next;
   logic       accept;
   logic       sample;
   logic       finish;
   logic       timer_load;
   logic       timer_zero;

   // Keep the timer parked at its reload value outside SETTLE so each vector
   // gets a full settle period, and reload it after every sample
   assign timer_load = (state != ST_SETTLE) || timer_zero;
   assign vec_inc    = vec + 2'd1;

   gate_bist_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .load(timer_load),
      .zero(timer_zero)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the accept/sample/finish strobes for the datapath
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      sample     = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (timer_zero) begin
               sample = 1'b1;
               if (vec == 2'd3) begin
                  finish     = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Truth table including the bit being sampled this cycle, so the final
   // verdict can be formed on the same edge that captures the last vector
   always_comb begin
      obs_next      = observed;
      obs_next[vec] = z;
   end

   // Stimulus registers: vector counter and the registered gate inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         vec <= 2'd0;
         x   <= 1'b0;
         y   <= 1'b0;
      end else if (accept) begin
         vec <= 2'd0;
         x   <= 1'b0;
         y   <= 1'b0;
      end else if (sample) begin
         if (finish) begin
            vec <= 2'd0;
            x   <= 1'b0;
            y   <= 1'b0;
         end else begin
            vec    <= vec_inc;
            {x, y} <= vec_inc;
         end
      end
   end

   // Status and result registers; results stay frozen from done until the
   // next accepted start clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         observed  <= 4'b0000;
         fail_mask <= 4'b0000;
      end else begin
         done <= 1'b0;
         if (accept) begin
            busy      <= 1'b1;
            pass      <= 1'b0;
            observed  <= 4'b0000;
            fail_mask <= 4'b0000;
         end else if (sample) begin
            observed <= obs_next;
            if (finish) begin
               busy      <= 1'b0;
               done      <= 1'b1;
               pass      <= (obs_next == EXPECTED);
               fail_mask <= obs_next ^ EXPECTED;
            end
         end
      end
   end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: default NAND configuration plus a
// single-cycle-settle XOR configuration.
module tb_gate_bist;
   import gate_bist_pkg::*;

   localparam int G_NAND   = 0;
   localparam int G_STUCK0 = 1;
   localparam int G_AND    = 2;

   logic       clk;
   logic       rst;
   logic       start;
   logic       start1;
   int         gate_sel;

   logic       z, x, y, busy, done, pass;
   logic [3:0] observed, fail_mask;
   logic       z1, x1, y1, busy1, done1, pass1;
   logic [3:0] observed1, fail_mask1;

   int checks;
   int failures;

   gate_bist #(
      .SETTLE_CYCLES(7),
      .EXPECTED     (TT_NAND)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .z        (z),
      .x        (x),
      .y        (y),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .observed (observed),
      .fail_mask(fail_mask)
   );

   gate_bist #(
      .SETTLE_CYCLES(1),
      .EXPECTED     (TT_XOR)
   ) dut1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .z        (z1),
      .x        (x1),
      .y        (y1),
      .busy     (busy1),
      .done     (done1),
      .pass     (pass1),
      .observed (observed1),
      .fail_mask(fail_mask1)
   );

   // Gate under test models
   always_comb begin
      z = 1'b0;
      case (gate_sel)
         G_NAND:   z = ~(x & y);
         G_STUCK0: z = 1'b0;
         G_AND:    z = x & y;
         default:  z = 1'b0;
      endcase
   end

   assign z1 = x1 ^ y1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Pulse start so it is sampled at "edge 0"; afterwards we sit in cycle 1
   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      start  = 1'b1;
      start1 = 1'b1;
      tick();
      tick();
      checks++; if ({x, y} !== 2'b00) begin failures++; $display("[TB] FAIL reset_xy actual=%b expected=00", {x, y}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b expected=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%b expected=0", done); end
      checks++; if (pass !== 1'b0) begin failures++; $display("[TB] FAIL reset_pass actual=%b expected=0", pass); end
      checks++; if (observed !== 4'b0000) begin failures++; $display("[TB] FAIL reset_observed actual=%b expected=0000", observed); end
      checks++; if (fail_mask !== 4'b0000) begin failures++; $display("[TB] FAIL reset_fail_mask actual=%b expected=0000", fail_mask); end
      checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy1 actual=%b expected=0", busy1); end
      rst    = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      tick();
   endtask

   task automatic test_good_nand();
      logic [1:0] exp_xy;
      gate_sel = G_NAND;
      start_pulse();
      for (int cyc = 1; cyc <= 30; cyc++) begin
         exp_xy = (cyc <= 28) ? 2'((cyc - 1) / 7) : 2'b00;
         checks++; if ({x, y} !== exp_xy) begin failures++; $display("[TB] FAIL nand_xy cycle=%0d actual=%b expected=%b", cyc, {x, y}, exp_xy); end
         checks++; if (busy !== (cyc <= 28)) begin failures++; $display("[TB] FAIL nand_busy cycle=%0d actual=%b expected=%b", cyc, busy, (cyc <= 28)); end
         checks++; if (done !== (cyc == 29)) begin failures++; $display("[TB] FAIL nand_done cycle=%0d actual=%b expected=%b", cyc, done, (cyc == 29)); end
         if (cyc == 29) begin
            checks++; if (pass !== 1'b1) begin failures++; $display("[TB] FAIL nand_pass actual=%b expected=1", pass); end
            checks++; if (observed !== 4'b0111) begin failures++; $display("[TB] FAIL nand_observed actual=%b expected=0111", observed); end
            checks++; if (fail_mask !== 4'b0000) begin failures++; $display("[TB] FAIL nand_fail_mask actual=%b expected=0000", fail_mask); end
         end
         tick();
      end
   endtask

   task automatic test_stuck0_back_to_back();
      gate_sel = G_STUCK0;
      start_pulse();
      run_cycles(28);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL stuck_done actual=%b expected=1", done); end
      checks++; if (pass !== 1'b0) begin failures++; $display("[TB] FAIL stuck_pass actual=%b expected=0", pass); end
      checks++; if (observed !== 4'b0000) begin failures++; $display("[TB] FAIL stuck_observed actual=%b expected=0000", observed); end
      checks++; if (fail_mask !== 4'b0111) begin failures++; $display("[TB] FAIL stuck_fail_mask actual=%b expected=0111", fail_mask); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_width actual=%b expected=0", done); end
      checks++; if (fail_mask !== 4'b0111) begin failures++; $display("[TB] FAIL b2b_hold_fail_mask actual=%b expected=0111", fail_mask); end
      gate_sel = G_NAND;
      start_pulse();
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy actual=%b expected=1", busy); end
      checks++; if (fail_mask !== 4'b0000) begin failures++; $display("[TB] FAIL b2b_clear_fail_mask actual=%b expected=0000", fail_mask); end
      run_cycles(28);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done actual=%b expected=1", done); end
      checks++; if (pass !== 1'b1) begin failures++; $display("[TB] FAIL b2b_pass actual=%b expected=1", pass); end
      tick();
   endtask

   task automatic test_and_gate();
      gate_sel = G_AND;
      start_pulse();
      run_cycles(28);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL and_done actual=%b expected=1", done); end
      checks++; if (observed !== 4'b1000) begin failures++; $display("[TB] FAIL and_observed actual=%b expected=1000", observed); end
      checks++; if (fail_mask !== 4'b1111) begin failures++; $display("[TB] FAIL and_fail_mask actual=%b expected=1111", fail_mask); end
      checks++; if (pass !== 1'b0) begin failures++; $display("[TB] FAIL and_pass actual=%b expected=0", pass); end
      tick();
   endtask

   task automatic test_start_ignored();
      int done_count;
      int done_cycle;
      done_count = 0;
      done_cycle = -1;
      gate_sel   = G_NAND;
      start_pulse();
      for (int cyc = 1; cyc <= 35; cyc++) begin
         if (done) begin
            done_count++;
            done_cycle = cyc;
         end
         start = (cyc == 10);
         tick();
      end
      start = 1'b0;
      checks++; if (done_count !== 1) begin failures++; $display("[TB] FAIL ignore_done_count actual=%0d expected=1", done_count); end
      checks++; if (done_cycle !== 29) begin failures++; $display("[TB] FAIL ignore_done_cycle actual=%0d expected=29", done_cycle); end
      checks++; if (pass !== 1'b1) begin failures++; $display("[TB] FAIL ignore_pass actual=%b expected=1", pass); end
   endtask

   task automatic test_reset_mid_run();
      gate_sel = G_NAND;
      start_pulse();
      run_cycles(15);
      checks++; if ({x, y} !== 2'b10) begin failures++; $display("[TB] FAIL midrst_pre_xy actual=%b expected=10", {x, y}); end
      checks++; if (observed !== 4'b0011) begin failures++; $display("[TB] FAIL midrst_pre_observed actual=%b expected=0011", observed); end
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      checks++; if ({x, y} !== 2'b00) begin failures++; $display("[TB] FAIL midrst_xy actual=%b expected=00", {x, y}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy actual=%b expected=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done actual=%b expected=0", done); end
      checks++; if (observed !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_observed actual=%b expected=0000", observed); end
      checks++; if (pass !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pass actual=%b expected=0", pass); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_idle_busy actual=%b expected=0", busy); end
      start_pulse();
      run_cycles(28);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL midrst_rerun_done actual=%b expected=1", done); end
      checks++; if (observed !== 4'b0111) begin failures++; $display("[TB] FAIL midrst_rerun_observed actual=%b expected=0111", observed); end
      checks++; if (pass !== 1'b1) begin failures++; $display("[TB] FAIL midrst_rerun_pass actual=%b expected=1", pass); end
      tick();
   endtask

   task automatic test_settle_one_xor();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         if (cyc <= 4) begin
            checks++; if ({x1, y1} !== 2'(cyc - 1)) begin failures++; $display("[TB] FAIL s1_xy cycle=%0d actual=%b expected=%b", cyc, {x1, y1}, 2'(cyc - 1)); end
         end
         checks++; if (done1 !== (cyc == 5)) begin failures++; $display("[TB] FAIL s1_done cycle=%0d actual=%b expected=%b", cyc, done1, (cyc == 5)); end
         checks++; if (busy1 !== (cyc <= 4)) begin failures++; $display("[TB] FAIL s1_busy cycle=%0d actual=%b expected=%b", cyc, busy1, (cyc <= 4)); end
         if (cyc == 5) begin
            checks++; if (observed1 !== 4'b0110) begin failures++; $display("[TB] FAIL s1_observed actual=%b expected=0110", observed1); end
            checks++; if (pass1 !== 1'b1) begin failures++; $display("[TB] FAIL s1_pass actual=%b expected=1", pass1); end
            checks++; if (fail_mask1 !== 4'b0000) begin failures++; $display("[TB] FAIL s1_fail_mask actual=%b expected=0000", fail_mask1); end
         end
         tick();
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      start    = 1'b0;
      start1   = 1'b0;
      gate_sel = G_NAND;
      #2;
      test_reset();
      test_good_nand();
      test_stuck0_back_to_back();
      test_and_gate();
      test_start_ignored();
      test_reset_mid_run();
      test_settle_one_xor();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
